// File: rtl/sr_using_jk_ff.sv
// Bank of WIDTH clocked SR flip-flops, each built on a JK flip-flop core.
// Optional SR_ILLEGAL_HOLD_EN: s=r=1 holds q and flags it on a registered illegal output.

module jk_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module sr_using_jk_ff #(
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef SR_ILLEGAL_HOLD_EN
  ,
  output logic [WIDTH-1:0] illegal
`endif
);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

`ifdef SR_ILLEGAL_HOLD_EN
  logic [WIDTH-1:0] illegal_reg;

  // Masking the 11 combination turns the JK toggle into a hold.
  assign j = s & ~r;
  assign k = r & ~s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_reg <= '0;
    end else begin
      illegal_reg <= s & r;
    end
  end

  assign illegal = illegal_reg;
`else
  assign j = s;
  assign k = r;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_ff #(
        .RST_VAL (RST_VAL[gi])
      ) u_jk (
        .clk (clk),
        .rst (rst),
        .j   (j[gi]),
        .k   (k[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

  assign qb = ~q;

endmodule

// File: tb/tb_sr_using_jk_ff.sv
// Self-checking bench for sr_using_jk_ff (WIDTH=4): directed steps, then random
// s/r with occasional asynchronous reset pulses, against a per-bit SR/JK reference.

module tb_sr_using_jk_ff;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic [W-1:0] q;
  logic [W-1:0] qb;
`ifdef SR_ILLEGAL_HOLD_EN
  logic [W-1:0] illegal;
  logic [W-1:0] ill_exp;
`endif

  logic [W-1:0] q_exp;
  int compared = 0;
  int mismatched = 0;

  sr_using_jk_ff #(
    .WIDTH   (W),
    .RST_VAL ('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .r   (r),
    .q   (q),
    .qb  (qb)
`ifdef SR_ILLEGAL_HOLD_EN
    ,
    .illegal (illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, q, q_exp);
    check({tag, ".qb"}, qb, ~q_exp);
`ifdef SR_ILLEGAL_HOLD_EN
    check({tag, ".illegal"}, illegal, ill_exp);
`endif
    $display("[%0t] %s s=%b r=%b q=%b qb=%b exp_q=%b", $time, tag, s, r, q, qb, q_exp);
  endtask

  // Reference: apply the SR truth table bit by bit to the current state.
  function automatic logic [W-1:0] sr_next(input logic [W-1:0] cur,
                                           input logic [W-1:0] sv,
                                           input logic [W-1:0] rv);
    logic [W-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < W; i++) begin
      if (sv[i] && rv[i]) begin
`ifdef SR_ILLEGAL_HOLD_EN
        nxt[i] = cur[i];
`else
        nxt[i] = !cur[i];
`endif
      end else if (sv[i]) begin
        nxt[i] = 1'b1;
      end else if (rv[i]) begin
        nxt[i] = 1'b0;
      end
    end
    return nxt;
  endfunction

  // Drive s/r away from the edge, predict, clock once, then check after the edge.
  task automatic step(input logic [W-1:0] sv, input logic [W-1:0] rv, input string tag);
    s = sv;
    r = rv;
    q_exp = sr_next(q_exp, sv, rv);
`ifdef SR_ILLEGAL_HOLD_EN
    ill_exp = sv & rv;
`endif
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    q_exp = '0;
`ifdef SR_ILLEGAL_HOLD_EN
    ill_exp = '0;
`endif
    #1;
    check_all(tag);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    s = '0;
    r = '0;
    q_exp = '0;
`ifdef SR_ILLEGAL_HOLD_EN
    ill_exp = '0;
`endif
    #2;
    check_all("reset_init");

    // Set requests toggling while reset is held must not disturb q.
    for (int i = 0; i < 4; i++) begin
      s = (i % 2 == 0) ? '1 : '0;
      r = '0;
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    rst = 1'b1;

    step(4'b0000, 4'b0000, "release_hold");
    step(4'b0000, 4'b0001, "reset_bit");
    step(4'b0000, 4'b0000, "hold0");
    step(4'b0001, 4'b0000, "set_bit");
    step(4'b0000, 4'b0000, "hold1");
    step(4'b0001, 4'b0001, "toggle_a");
    step(4'b0001, 4'b0001, "toggle_b");
    step(4'b0000, 4'b0000, "hold_after_toggle");

    async_reset("async_mid");
    step(4'b0001, 4'b0000, "set_after_release");
    step(4'b0000, 4'b1111, "clear_all");
    step(4'b0101, 4'b0011, "w4_mix");
    step(4'b1111, 4'b1111, "all_11");
    step(4'b0000, 4'b0000, "all_hold");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) async_reset("rand_async");
      step(W'($urandom), W'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
